// File: rtl/hemps_defaults_pkg.sv
// Shared Hermes router constants and the input-buffer state encoding.
package hemps_defaults;
  localparam int TAM_FLIT = 16;
  localparam int NPORT = 5;
  localparam int BUFFER_DEPTH_DFLT = 16;

  typedef logic [TAM_FLIT-1:0] regflit;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROUTE,
    S_HDR,
    S_SIZE,
    S_PAYLOAD
  } buf_state_t;
endpackage

// File: rtl/hermes_input_buffer_if.sv
// Link-side and crossbar-side signals of one Hermes input port.
interface hermes_input_buffer_if #(
  parameter int TAM_FLIT = hemps_defaults::TAM_FLIT
);
  logic                rx;
  logic [TAM_FLIT-1:0] data_in;
  logic                credit_o;
  logic                h;
  logic                ack_h;
  logic                data_av;
  logic [TAM_FLIT-1:0] data;
  logic                data_ack;
  logic                sender;

  modport master (
    output rx, data_in, ack_h, data_ack,
    input  credit_o, h, data_av, data, sender
  );

  modport slave (
    input  rx, data_in, ack_h, data_ack,
    output credit_o, h, data_av, data, sender
  );
endinterface

// File: rtl/hermes_flit_fifo.sv
// Circular flit store with first-word-fall-through head and an occupancy count.
module hermes_flit_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [W-1:0]             din,
  input  logic                     rd,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;

  // Storage is cleared on reset so the head reads zero and stale flits never reappear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + {{PTR_W{1'b0}}, wr} - {{PTR_W{1'b0}}, rd};
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/hermes_input_buffer.sv
// Hermes input port: buffers link flits, requests a route per packet and streams
// header, size and payload to the crossbar.
module hermes_input_buffer #(
  parameter int TAM_FLIT     = hemps_defaults::TAM_FLIT,
  parameter int BUFFER_DEPTH = hemps_defaults::BUFFER_DEPTH_DFLT
) (
  input logic                  clock,
  input logic                  reset,
  input logic                  clock_rx,
  hermes_input_buffer_if.slave bus
);
  import hemps_defaults::*;

  localparam int PTR_W = $clog2(BUFFER_DEPTH);

  buf_state_t          state;
  logic [TAM_FLIT-1:0] flit_cnt;
  logic                h_q;
  logic                sender_q;
  logic                wr;
  logic                pop;
  logic                full;
  logic                empty;
  logic                data_av;
  logic [TAM_FLIT-1:0] head;
  logic [PTR_W:0]      count;

  // The link clock is not used; everything runs on the router clock.
  logic unused_clock_rx;
  assign unused_clock_rx = clock_rx;

  assign wr      = bus.rx && !full;
  assign data_av = sender_q && !empty &&
                   (state == S_HDR || state == S_SIZE || state == S_PAYLOAD);
  assign pop     = data_av && bus.data_ack;

  hermes_flit_fifo #(.W(TAM_FLIT), .DEPTH(BUFFER_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .wr    (wr),
    .din   (bus.data_in),
    .rd    (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      flit_cnt <= '0;
      h_q      <= 1'b0;
      sender_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          h_q   <= 1'b1;
          state <= S_ROUTE;
        end
        S_ROUTE: if (bus.ack_h) begin
          h_q      <= 1'b0;
          sender_q <= 1'b1;
          state    <= S_HDR;
        end
        S_HDR: if (pop) state <= S_SIZE;
        S_SIZE: if (pop) begin
          flit_cnt <= head;
          if (head == '0) begin
            sender_q <= 1'b0;
            state    <= S_IDLE;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (pop) begin
          flit_cnt <= flit_cnt - TAM_FLIT'(1);
          // Last payload flit closes the connection on the same edge it is consumed.
          if (flit_cnt == TAM_FLIT'(1)) begin
            sender_q <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.credit_o = !full;
  assign bus.h        = h_q;
  assign bus.sender   = sender_q;
  assign bus.data_av  = data_av;
  assign bus.data     = head;
endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer: reset, packet flow, backpressure, wrap, reset.
module tb_hermes_input_buffer;
  import hemps_defaults::*;

  logic clock = 1'b0;
  logic clock_rx = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;
  logic [15:0] q[$];

  hermes_input_buffer_if bus();

  hermes_input_buffer dut (
    .clock    (clock),
    .reset    (reset),
    .clock_rx (clock_rx),
    .bus      (bus)
  );

  always #5 clock = ~clock;
  always #7 clock_rx = ~clock_rx;

  // Record every flit the crossbar consumes.
  always @(negedge clock)
    if (bus.data_av && bus.data_ack) q.push_back(bus.data);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rx = 1'b0; bus.data_in = '0; bus.ack_h = 1'b0; bus.data_ack = 1'b0;
  endtask

  task automatic wait_pops(input int n, input string name);
    int k;
    k = 0;
    while (q.size() < n && k < 60) begin tick(); k++; end
    if (q.size() < n) begin
      total++;
      $display("FAIL %s_timeout: got %0d pops want %0d", name, q.size(), n);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    total++;
    if (bus.data !== 16'h0) $display("FAIL rst_data: got %h want 0000", bus.data);
    else passed++;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({bus.credit_o, bus.h, bus.sender, bus.data_av} !== 4'b1000)
        $display("FAIL rst_idle_%0d: got c/h/s/av=%b want 1000", i,
                 {bus.credit_o, bus.h, bus.sender, bus.data_av});
      else passed++;
    end
  endtask

  task automatic test_single_packet();
    logic [15:0] f[4] = '{16'h0011, 16'h0002, 16'hAAAA, 16'hBBBB};
    q.delete();
    bus.data_ack = 1'b1;
    bus.rx = 1'b1; bus.data_in = f[0]; tick();
    total++;
    if (bus.h !== 1'b0) $display("FAIL pkt_h_early: got %b want 0", bus.h); else passed++;
    bus.data_in = f[1]; tick();
    total++;
    if (bus.h !== 1'b1) $display("FAIL pkt_h_rise: got %b want 1", bus.h); else passed++;
    bus.data_in = f[2]; tick();
    bus.data_in = f[3]; tick();
    bus.rx = 1'b0; bus.ack_h = 1'b1; tick();
    bus.ack_h = 1'b0;
    total++;
    if ({bus.h, bus.sender} !== 2'b01)
      $display("FAIL pkt_ack: got h/s=%b want 01", {bus.h, bus.sender});
    else passed++;
    wait_pops(4, "pkt");
    total++;
    if ({bus.sender, bus.data_av} !== 2'b00)
      $display("FAIL pkt_sender_fall: got s/av=%b want 00", {bus.sender, bus.data_av});
    else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (q.size() <= i || q[i] !== f[i])
        $display("FAIL pkt_flit_%0d: got %h want %h", i, (q.size() > i) ? q[i] : 16'hxxxx, f[i]);
      else passed++;
    end
  endtask

  task automatic test_zero_size();
    q.delete();
    bus.data_ack = 1'b1;
    bus.rx = 1'b1; bus.data_in = 16'h0022; tick();
    bus.data_in = 16'h0000; tick();
    bus.rx = 1'b0; bus.ack_h = 1'b1; tick();
    bus.ack_h = 1'b0;
    wait_pops(2, "zero");
    total++;
    if (bus.sender !== 1'b0 || dut.state !== S_IDLE)
      $display("FAIL zero_end: got sender=%b state=%0d want 0/%0d", bus.sender, dut.state, S_IDLE);
    else passed++;
    tick(); tick(); tick();
    total++;
    if (q.size() !== 2 || bus.h !== 1'b0)
      $display("FAIL zero_pops: got pops=%0d h=%b want 2/0", q.size(), bus.h);
    else passed++;
    total++;
    if (q.size() < 2 || q[0] !== 16'h0022 || q[1] !== 16'h0000)
      $display("FAIL zero_flits: got %h %h want 0022 0000",
               (q.size() > 0) ? q[0] : 16'hxxxx, (q.size() > 1) ? q[1] : 16'hxxxx);
    else passed++;
  endtask

  task automatic test_full();
    logic [15:0] f[16];
    int bad;
    q.delete();
    bus.data_ack = 1'b0;
    f[0] = 16'h0033; f[1] = 16'h000E;
    for (int i = 2; i < 16; i++) f[i] = 16'h0100 + 16'(i);
    for (int i = 0; i < 16; i++) begin
      bus.rx = 1'b1; bus.data_in = f[i]; tick();
      if (i == 14) begin
        total++;
        if (bus.credit_o !== 1'b1) $display("FAIL full_15: got credit %b want 1", bus.credit_o);
        else passed++;
      end
    end
    total++;
    if (bus.credit_o !== 1'b0) $display("FAIL full_16: got credit %b want 0", bus.credit_o);
    else passed++;
    bus.data_in = 16'hDEAD; tick();
    bus.rx = 1'b0;
    total++;
    if (bus.credit_o !== 1'b0 || dut.u_fifo.count !== 5'd16)
      $display("FAIL full_17: got credit=%b count=%0d want 0/16", bus.credit_o, dut.u_fifo.count);
    else passed++;
    bus.ack_h = 1'b1; tick();
    bus.ack_h = 1'b0;
    total++;
    if (bus.data_av !== 1'b1 || bus.data !== 16'h0033)
      $display("FAIL full_head: got av=%b data=%h want 1/0033", bus.data_av, bus.data);
    else passed++;
    bus.data_ack = 1'b1;
    total++;
    if (bus.credit_o !== 1'b0) $display("FAIL full_popcyc: got credit %b want 0", bus.credit_o);
    else passed++;
    tick();
    bus.data_ack = 1'b0;
    total++;
    if (bus.credit_o !== 1'b1) $display("FAIL full_rerise: got credit %b want 1", bus.credit_o);
    else passed++;
    bus.data_ack = 1'b1;
    wait_pops(16, "full");
    tick(); tick(); tick();
    bad = 0;
    for (int i = 0; i < 16; i++) if (q.size() <= i || q[i] !== f[i]) bad++;
    total++;
    if (bad != 0 || q.size() != 16 || bus.h !== 1'b0)
      $display("FAIL full_drain: got bad=%0d pops=%0d h=%b want 0/16/0", bad, q.size(), bus.h);
    else passed++;
  endtask

  task automatic test_wrap_stream();
    logic [15:0] g[40];
    int bad;
    q.delete();
    g[0] = 16'h0044; g[1] = 16'd38;
    for (int i = 2; i < 40; i++) g[i] = 16'h2000 + 16'(i);
    bus.ack_h = 1'b1; bus.data_ack = 1'b1;
    for (int i = 0; i < 40; i++) begin
      bus.rx = 1'b1; bus.data_in = g[i]; tick();
      if (i == 20 || i == 35) begin
        total++;
        if (dut.u_fifo.count !== 5'd3 || bus.credit_o !== 1'b1)
          $display("FAIL wrap_count_%0d: got count=%0d credit=%b want 3/1", i,
                   dut.u_fifo.count, bus.credit_o);
        else passed++;
      end
    end
    bus.rx = 1'b0;
    wait_pops(40, "wrap");
    bus.ack_h = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) if (q.size() <= i || q[i] !== g[i]) bad++;
    total++;
    if (bad != 0 || bus.sender !== 1'b0)
      $display("FAIL wrap_order: got bad=%0d sender=%b want 0/0", bad, bus.sender);
    else passed++;
  endtask

  task automatic test_reset_mid_packet();
    logic [15:0] f[4] = '{16'h0055, 16'h0005, 16'h3001, 16'h3002};
    logic [15:0] c[3] = '{16'h0066, 16'h0001, 16'h1234};
    int bad;
    q.delete();
    bus.ack_h = 1'b1; bus.data_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin bus.rx = 1'b1; bus.data_in = f[i]; tick(); end
    bus.rx = 1'b0;
    repeat (4) tick();
    total++;
    if (dut.state !== S_PAYLOAD || bus.sender !== 1'b1 || bus.data_av !== 1'b0)
      $display("FAIL mid_hold: got state=%0d s=%b av=%b want %0d/1/0", dut.state,
               bus.sender, bus.data_av, S_PAYLOAD);
    else passed++;
    bus.data_ack = 1'b0; bus.rx = 1'b1; bus.data_in = 16'h3003; tick();
    bus.rx = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.credit_o, bus.h, bus.sender, bus.data_av} !== 4'b1000 || bus.data !== 16'h0)
      $display("FAIL mid_reset: got c/h/s/av=%b data=%h want 1000/0000",
               {bus.credit_o, bus.h, bus.sender, bus.data_av}, bus.data);
    else passed++;
    tick();
    reset = 1'b0;
    q.delete();
    bus.ack_h = 1'b1; bus.data_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.rx = 1'b1; bus.data_in = c[i]; tick(); end
    bus.rx = 1'b0;
    wait_pops(3, "post");
    tick(); tick();
    bus.ack_h = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) if (q.size() <= i || q[i] !== c[i]) bad++;
    total++;
    if (bad != 0 || q.size() != 3 || bus.sender !== 1'b0)
      $display("FAIL post_pkt: got bad=%0d pops=%0d s=%b want 0/3/0", bad, q.size(), bus.sender);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    idle_inputs(); tick();
    test_zero_size();
    idle_inputs(); tick();
    test_full();
    idle_inputs(); tick();
    test_wrap_stream();
    idle_inputs(); tick();
    test_reset_mid_packet();
    idle_inputs(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
